// File: rtl/paillier_task_server.sv
// paillier_task_server: runs Paillier encrypt, decrypt and rng tasks as short
// sequences of requests to an external modular-arithmetic engine.
// Ports:
//   clk, rst_n                        clock; asynchronous active-low reset
//   start, my_task, data_in           task request pulse, task code
//                                     (00 enc, 01 dec, 10 rng, 11 reserved), operand
//   done, data_out                    one-cycle completion pulse; registered result
//   eng_start, eng_op, eng_a, eng_b   engine request pulse, op code and operands
//                                     (operands held from eng_start until eng_done)
//   eng_done, eng_result              engine completion pulse and result
module paillier_task_server #(
    parameter int                DATA_W      = 528,
    parameter logic [DATA_W-1:0] N           = DATA_W'(256'hC7F1_9A3D_5B2E_8F04_6D1C_A9B7_3E58_F2D6_1B4A_7C9E_0F35_D8A2_6B1E_94C7_3F5D_A28B),
    parameter logic [DATA_W-1:0] N2          = N * N,
    parameter logic [DATA_W-1:0] LAMBDA      = DATA_W'(256'h63F8_CD1E_AD97_4782_368E_54DB_9F2C_796B_0DA5_3E4F_079A_EC51_358F_4A63_9FAE_5144),
    parameter logic [DATA_W-1:0] MU          = DATA_W'(256'h2A6F_1C83_9E4D_B057_7F12_E6A9_C3D8_5B40_91E7_6A2C_D4F3_08B5_E19A_7C6D_3B52_F8E1),
    parameter logic [DATA_W-1:0] RANDOM_SEED = DATA_W'(256'h1F2E_3D4C_5B6A_7988_96A5_B4C3_D2E1_F00F_E1D2_C3B4_A596_8778_695A_4B3C_2D1E_0F21)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        my_task,
    input  logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              eng_start,
    output logic [1:0]        eng_op,
    output logic [DATA_W-1:0] eng_a,
    output logic [DATA_W-1:0] eng_b,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_result
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    localparam logic [1:0] T_ENC = 2'b00;
    localparam logic [1:0] T_DEC = 2'b01;
    localparam logic [1:0] T_RNG = 2'b10;
    localparam logic [1:0] T_RSV = 2'b11;

    localparam logic [1:0] OP_POW_N2 = 2'b00;
    localparam logic [1:0] OP_MUL_N2 = 2'b01;
    localparam logic [1:0] OP_DIV_N  = 2'b10;
    localparam logic [1:0] OP_MUL_N  = 2'b11;

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_step;
    logic [1:0]        r_task;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_t;
    logic [DATA_W-1:0] r_t1;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_data_out;
    logic              r_done;

    logic              w_accept;
    logic              w_last;
    logic              w_busy;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    // done is registered, so the FSM is already back in IDLE during the done
    // cycle; gating on r_done keeps a start in that cycle from being taken.
    assign w_accept = (r_state == S_IDLE) && start && !r_done;
    assign w_last   = (r_task == T_RNG) || (r_step == 2'd2);
    assign w_busy   = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Operand selection per task/step. r_t holds the latest engine result and
    // r_t1 the step-0 result, which encrypt needs again in step 2.
    always_comb begin
        w_op = OP_MUL_N2;
        w_a  = r_r;
        w_b  = r_r;
        if (r_task == T_ENC) begin
            w_op = (r_step == 2'd0) ? OP_POW_N2 : OP_MUL_N2;
            w_a  = (r_step == 2'd0) ? r_r : (r_step == 2'd1) ? r_data : r_t1;
            w_b  = (r_step == 2'd2) ? r_t + ONE : N;
        end else if (r_task == T_DEC) begin
            w_op = (r_step == 2'd0) ? OP_POW_N2 : (r_step == 2'd1) ? OP_DIV_N : OP_MUL_N;
            w_a  = (r_step == 2'd0) ? r_data : (r_step == 2'd1) ? r_t - ONE : r_t;
            w_b  = (r_step == 2'd0) ? LAMBDA : (r_step == 2'd1) ? '0 : MU;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = (my_task == T_RSV) ? S_FINISH : S_ISSUE;
            S_ISSUE: w_state_nx = S_WAIT;
            S_WAIT:  if (eng_done) w_state_nx = w_last ? S_FINISH : S_ISSUE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step     <= '0;
            r_task     <= '0;
            r_data     <= '0;
            r_t        <= '0;
            r_t1       <= '0;
            r_r        <= RANDOM_SEED;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (w_accept) begin
                r_task <= my_task;
                r_data <= data_in;
                r_step <= '0;
            end
            if (r_state == S_WAIT && eng_done) begin
                r_t <= eng_result;
                if (r_step == 2'd0) r_t1 <= eng_result;
                if (!w_last) r_step <= r_step + 2'd1;
            end
            if (r_state == S_FINISH) begin
                r_data_out <= (r_task == T_RSV) ? '0 : r_t;
                if (r_task == T_RNG) r_r <= r_t;
            end
        end
    end

    assign done      = r_done;
    assign data_out  = r_data_out;
    assign eng_start = (r_state == S_ISSUE);
    assign eng_op    = w_busy ? w_op : 2'b00;
    assign eng_a     = w_busy ? w_a : '0;
    assign eng_b     = w_busy ? w_b : '0;

endmodule

// File: tb/tb_paillier_task_server.sv
// tb_paillier_task_server: randomized self-checking bench for paillier_task_server
// with a toy key (N=15) and a behavioural engine of programmable wait.
module tb_paillier_task_server;

    localparam int     DW    = 528;
    localparam longint KN    = 15;
    localparam longint KN2   = 225;
    localparam longint KL    = 4;
    localparam longint KMU   = 4;
    localparam longint KSEED = 2;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    my_task = 2'b00;
    logic [DW-1:0] data_in = '0;
    logic          done;
    logic [DW-1:0] data_out;
    logic          eng_start;
    logic [1:0]    eng_op;
    logic [DW-1:0] eng_a;
    logic [DW-1:0] eng_b;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_result = '0;

    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    int     req_cnt = 0;
    int     eng_wait = 3;
    bit     inject = 1'b0;
    bit     inject_seen = 1'b0;
    longint rm = KSEED;
    req_t   eng_log[$];

    paillier_task_server #(
        .DATA_W(DW), .N(DW'(KN)), .N2(DW'(KN2)), .LAMBDA(DW'(KL)),
        .MU(DW'(KMU)), .RANDOM_SEED(DW'(KSEED))
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .my_task(my_task), .data_in(data_in),
        .done(done), .data_out(data_out), .eng_start(eng_start), .eng_op(eng_op),
        .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (eng_start === 1'b1) req_cnt++;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic longint powmod(longint base, longint e, longint m);
        longint acc = 1;
        for (longint i = 0; i < e; i++) acc = (acc * (base % m)) % m;
        return acc;
    endfunction

    function automatic logic [DW-1:0] eng_calc(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        longint x = longint'(a[62:0]);
        longint y = longint'(b[62:0]);
        case (op)
            2'b00:   return DW'(powmod(x, y, KN2));
            2'b01:   return DW'((x * y) % KN2);
            2'b10:   return DW'(x / KN);
            default: return DW'((x * y) % KN);
        endcase
    endfunction

    // Behavioural engine: result arrives eng_wait cycles after the request is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                req_t q;
                q.op = eng_op;
                q.a  = eng_a;
                q.b  = eng_b;
                eng_log.push_back(q);
                @(posedge clk);
                repeat (eng_wait) @(posedge clk);
                #1 eng_result = eng_calc(q.op, q.a, q.b);
                eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end else if (inject != inject_seen) begin
                inject_seen = inject;
                @(posedge clk);
                #1 eng_done = 1'b1;
                eng_result = '1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rm = KSEED;
    endtask

    // Runs one task and checks result, latency, done count and engine requests
    // against the Paillier formulas. disturb adds a start during WAIT and a
    // start in the done cycle, both of which must be ignored.
    task automatic do_task(input logic [1:0] tsk, input longint din, input int w, input bit disturb);
        req_t   exp_q[$];
        longint res, rn, u;
        int     s, d0, r0, lat, k;
        eng_wait = w;
        case (tsk)
            2'b00: begin
                rn = powmod(rm, KN, KN2);
                exp_q.push_back('{2'b00, DW'(rm), DW'(KN)});
                exp_q.push_back('{2'b01, DW'(din), DW'(KN)});
                exp_q.push_back('{2'b01, DW'(rn), DW'(((din * KN) % KN2) + 1)});
                res = (powmod(KN + 1, din, KN2) * rn) % KN2;
            end
            2'b01: begin
                u = powmod(din, KL, KN2);
                exp_q.push_back('{2'b00, DW'(din), DW'(KL)});
                exp_q.push_back('{2'b10, DW'(u - 1), '0});
                exp_q.push_back('{2'b11, DW'((u - 1) / KN), DW'(KMU)});
                res = (((u - 1) / KN) * KMU) % KN;
            end
            2'b10: begin
                exp_q.push_back('{2'b01, DW'(rm), DW'(rm)});
                res = (rm * rm) % KN2;
            end
            default: res = 0;
        endcase
        eng_log.delete();
        d0 = done_cnt;
        r0 = req_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        my_task = tsk;
        data_in = DW'(din);
        s = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        my_task = 2'($urandom);
        data_in = DW'($urandom);
        if (disturb && tsk != 2'b11) begin
            @(posedge clk);
            #1 start = 1'b1;
            my_task = 2'b11;
            @(posedge clk);
            #1 start = 1'b0;
        end
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        lat = cyc - s;
        if (disturb) begin
            start = 1'b1;
            my_task = 2'b11;
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        check("done_count", DW'(done_cnt - d0), DW'(1));
        check("latency", DW'(lat), DW'(2 + exp_q.size() * (2 + w)));
        check("data_out", data_out, DW'(res));
        check("req_count", DW'(req_cnt - r0), DW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++) begin
            check($sformatf("req%0d_op", i), DW'(eng_log[i].op), DW'(exp_q[i].op));
            check($sformatf("req%0d_a", i), eng_log[i].a, exp_q[i].a);
            if (exp_q[i].op != 2'b10) check($sformatf("req%0d_b", i), eng_log[i].b, exp_q[i].b);
        end
        if (tsk == 2'b10) rm = res;
    endtask

    initial begin
        longint m, c, prev;
        int d0, r0, k;
        @(posedge clk);
        #1;
        check("rst_done", DW'(done), '0);
        check("rst_data_out", data_out, '0);
        check("rst_eng_start", DW'(eng_start), '0);
        check("rst_eng_op", DW'(eng_op), '0);
        check("rst_eng_a", eng_a, '0);
        check("rst_eng_b", eng_b, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_task(2'b00, 7, 3, 1'b0);
        check("enc7_r2", data_out, DW'(83));
        do_task(2'b01, 83, 3, 1'b0);
        check("dec83", data_out, DW'(7));
        do_task(2'b10, 0, 3, 1'b0);
        check("rng1", data_out, DW'(4));
        do_task(2'b10, 0, 3, 1'b0);
        check("rng2", data_out, DW'(16));

        do_reset();
        do_task(2'b10, 0, 3, 1'b0);
        do_task(2'b00, 7, 3, 1'b0);
        do_task(2'b11, 5, 3, 1'b0);
        do_task(2'b01, 83, 3, 1'b1);
        do_task(2'b00, 11, 2, 1'b1);

        prev = longint'(data_out[62:0]);
        d0 = done_cnt;
        r0 = req_cnt;
        inject = ~inject;
        repeat (6) @(negedge clk);
        check("spur_done", DW'(done_cnt - d0), '0);
        check("spur_req", DW'(req_cnt - r0), '0);
        check("spur_data_out", data_out, DW'(prev));

        eng_wait = 3;
        d0 = done_cnt;
        r0 = req_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        my_task = 2'b01;
        data_in = DW'(83);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (req_cnt - r0 < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_done", DW'(done), '0);
        check("abort_eng_start", DW'(eng_start), '0);
        check("abort_eng_op", DW'(eng_op), '0);
        check("abort_eng_a", eng_a, '0);
        check("abort_eng_b", eng_b, '0);
        check("abort_data_out", data_out, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rm = KSEED;
        repeat (10) @(negedge clk);
        check("abort_no_done", DW'(done_cnt - d0), '0);
        check("abort_reqs", DW'(req_cnt - r0), DW'(2));
        do_task(2'b10, 0, 3, 1'b0);
        check("abort_rng", data_out, DW'(4));

        for (int i = 0; i < 30; i++) begin
            logic [1:0] t;
            t = 2'($urandom);
            if (t == 2'b00) begin
                m = longint'($urandom_range(0, 14));
                do_task(2'b00, m, $urandom_range(0, 4), i[0]);
                do_task(2'b01, longint'(data_out[62:0]), $urandom_range(0, 4), 1'b0);
                check("roundtrip", data_out, DW'(m));
            end else if (t == 2'b01) begin
                do c = longint'($urandom_range(1, 224)); while (c % 3 == 0 || c % 5 == 0);
                do_task(2'b01, c, $urandom_range(0, 4), i[0]);
            end else begin
                do_task(t, longint'($urandom_range(0, 224)), $urandom_range(0, 4), i[0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
